fc_score_collector: RTL and testbench
=====================================

Name: fc_score_collector

Overview:
- Final stage of the fully-connected output layer, directly upstream of the argmax (max-finder) block.
- Accumulates a serial stream of 32-bit product terms into NUM_CLASSES unsigned class scores, one class after another.
- Presents all scores as one packed vector with a level valid. The argmax stage samples the vector on that valid's rising edge.

Parameters:
- NUM_CLASSES, 10, number of output classes/score slots
- SCORE_WIDTH, 32, width of each term and score, unsigned
- IDX_WIDTH, 4, width of class index; must satisfy 2^IDX_WIDTH >= NUM_CLASSES

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous frame abort, active high
- in_valid  in  1  term valid
- in_ready  out  1  collector can accept a term
- in_data  in  SCORE_WIDTH  unsigned product term
- in_last  in  1  term is the final term of the current class
- out_valid  out  1  packed scores valid, held until accepted
- out_ready  in  1  consumer accepts packed scores
- out_scores  out  NUM_CLASSES*SCORE_WIDTH  class k at bits [k*SCORE_WIDTH +: SCORE_WIDTH], class 0 in LSBs
- out_class_cnt  out  IDX_WIDTH  index of the class currently accumulating (debug)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=ACCUM, accumulator=0, class index=0, all slots=0.
  - Output reset values: out_valid=0, out_scores=0, in_ready=1, out_class_cnt=0.
- States: ACCUM, OUT.
- ACCUM:
  - in_ready=1. A term is accepted when in_valid && in_ready.
  - Accepted term without in_last: acc <= acc + in_data.
  - Accepted term with in_last: slot[idx] <= acc + in_data; acc <= 0.
    - If idx == NUM_CLASSES-1: idx <= 0 and state <= OUT.
    - Otherwise idx <= idx+1.
- A class may consist of a single term (in_last on its first beat): slot = in_data.
- Arithmetic: SCORE_WIDTH-bit unsigned addition, modulo 2^SCORE_WIDTH (wrap) unless SCORE_SAT_EN is defined.
- OUT:
  - in_ready=0, out_valid=1.
  - out_scores is stable and equals the registered slots; the slots are not modified while in OUT.
  - On out_valid && out_ready: out_valid<=0 and state<=ACCUM. in_ready returns to 1 the next cycle; it is never combinationally tied to out_ready.
- Latency: out_valid rises in the cycle after the final class's last term is accepted.
- clear (synchronous, highest priority after reset):
  - acc=0, idx=0, state=ACCUM, out_valid=0; slots retain their values.
  - A term presented in the same cycle as clear is dropped, with no accumulation.
- in_valid high while in OUT: the term is ignored. The source must hold it until in_ready.
- rst_n asserted mid-frame or mid-OUT: immediate return to reset values. The partial frame is lost.
- in_last is ignored unless the beat is accepted.

Optional Feature:
- Macro: SCORE_SAT_EN
- Defined: each add saturates to all-ones (32'hFFFFFFFF) on unsigned carry-out. Once saturated, a score stays saturated for the rest of its class.
- Undefined: modulo wrap, e.g. 32'hFFFFFFFF + 1 = 0.

Decomposition:
- Package cnn_fpga_pkg:
  - NUM_CLASSES, SCORE_WIDTH, IDX_WIDTH constants.
  - Packed-vector width constant NUM_CLASSES*SCORE_WIDTH.
  - State enum {ACCUM, OUT}.
- One sub-module, score_add: combinational SCORE_WIDTH adder implementing wrap or saturate under SCORE_SAT_EN. It is instantiated once, for the accumulator path.

Test Plan:
- Single-term classes, in_data = 10 classes with values 5,9,1,3,7,2,8,4,6,0 each with in_last:
  - out_valid rises one cycle after the 10th term.
  - out_scores[63:32]=9; the downstream argmax reports 1.
- Multi-term class 0 = 100+200+300, classes 1..9 = 1:
  - out_scores[31:0]=600, every other slot = 1.
  - out_class_cnt steps 0..9.
- Backpressure:
  - Hold out_ready=0 for 20 cycles with in_valid=1: in_ready stays 0, out_scores stays stable, no term is consumed.
  - Then raise out_ready: out_valid falls and in_ready=1 on the next cycle.
- Overflow, class 0 = 32'hFFFFFFFF + 2:
  - Without SCORE_SAT_EN: slot = 1.
  - With SCORE_SAT_EN: slot = 32'hFFFFFFFF.
- clear after 4 classes plus a partial term:
  - A new full frame yields only the new values; no stale accumulator carries over.
  - A term in the clear cycle is dropped.
- rst_n pulled low during OUT:
  - out_valid=0 and out_scores=0 asynchronously.
  - After release, a following frame of all-7 terms gives all slots = 7.

Source files
------------

// File: rtl/cnn_fpga_pkg.sv
// cnn_fpga_pkg: shared constants and state encoding for the FC score collector.
package cnn_fpga_pkg;
    localparam int NUM_CLASSES  = 10;
    localparam int SCORE_WIDTH  = 32;
    localparam int IDX_WIDTH    = 4;
    localparam int PACKED_WIDTH = NUM_CLASSES * SCORE_WIDTH;
    typedef enum logic {ACCUM, OUT} state_e;
endpackage

// File: rtl/score_add.sv
// score_add: unsigned score adder; wraps modulo 2^SCORE_WIDTH, or saturates to all-ones
// on carry-out when SCORE_SAT_EN is defined.
module score_add
    import cnn_fpga_pkg::*;
(
    input  logic [SCORE_WIDTH-1:0] a,
    input  logic [SCORE_WIDTH-1:0] b,
    output logic [SCORE_WIDTH-1:0] sum
);
`ifdef SCORE_SAT_EN
    logic [SCORE_WIDTH:0] full;
    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = full[SCORE_WIDTH] ? '1 : full[SCORE_WIDTH-1:0];
`else
    assign sum = a + b;
`endif
endmodule

// File: rtl/fc_score_collector.sv
// fc_score_collector: accumulates serial product terms into NUM_CLASSES class scores
// and presents them as one packed vector. Saturating adds when SCORE_SAT_EN is defined.
module fc_score_collector
    import cnn_fpga_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SCORE_WIDTH-1:0]  in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PACKED_WIDTH-1:0] out_scores,
    output logic [IDX_WIDTH-1:0]    out_class_cnt
);
    state_e                  state_q, state_d;
    logic [SCORE_WIDTH-1:0]  acc_q, acc_d, sum;
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;
    logic [PACKED_WIDTH-1:0] scores_q, scores_d;

    score_add u_add (.a(acc_q), .b(in_data), .sum(sum));

    assign in_ready      = (state_q == ACCUM);
    assign out_valid     = (state_q == OUT);
    assign out_scores    = scores_q;
    assign out_class_cnt = idx_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        scores_d = scores_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            idx_d   = '0;
        end else if (state_q == ACCUM && in_valid) begin
            if (in_last) begin
                scores_d[idx_q*SCORE_WIDTH +: SCORE_WIDTH] = sum;
                acc_d = '0;
                if (idx_q == IDX_WIDTH'(NUM_CLASSES - 1)) begin
                    idx_d   = '0;
                    state_d = OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                acc_d = sum;
            end
        end else if (state_q == OUT && out_ready) begin
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACCUM;
            acc_q    <= '0;
            idx_q    <= '0;
            scores_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            scores_q <= scores_d;
        end
    end
endmodule

// File: tb/tb_fc_score_collector.sv
// tb_fc_score_collector: directed-vector bench for fc_score_collector (honours SCORE_SAT_EN).
module tb_fc_score_collector;
    import cnn_fpga_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n, clear, in_valid, in_last, out_ready;
    logic [SCORE_WIDTH-1:0]  in_data;
    logic                    in_ready, out_valid;
    logic [PACKED_WIDTH-1:0] out_scores;
    logic [IDX_WIDTH-1:0]    out_class_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [SCORE_WIDTH-1:0] vals [NUM_CLASSES];
    logic [PACKED_WIDTH-1:0] exp_vec;

    fc_score_collector dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_scores(out_scores), .out_class_cnt(out_class_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [PACKED_WIDTH-1:0] got,
                         input logic [PACKED_WIDTH-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic beat(input logic [SCORE_WIDTH-1:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic logic [PACKED_WIDTH-1:0] pack_vals();
        logic [PACKED_WIDTH-1:0] v;
        for (int k = 0; k < NUM_CLASSES; k++) v[k*SCORE_WIDTH +: SCORE_WIDTH] = vals[k];
        return v;
    endfunction

    // One single-term beat per class; valid must rise only after the last class.
    task automatic frame_single(input string tag);
        for (int k = 0; k < NUM_CLASSES; k++) begin
            check({tag, "_cnt"}, PACKED_WIDTH'(out_class_cnt), PACKED_WIDTH'(k));
            beat(vals[k], 1'b1);
            check({tag, "_valid"}, PACKED_WIDTH'(out_valid), PACKED_WIDTH'(k == NUM_CLASSES - 1));
        end
    endtask

    task automatic accept_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_fall"}, PACKED_WIDTH'(out_valid), '0);
        check({tag, "_ready_back"}, PACKED_WIDTH'(in_ready), PACKED_WIDTH'(1));
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", PACKED_WIDTH'(out_valid), '0);
        check("rst_ready", PACKED_WIDTH'(in_ready), PACKED_WIDTH'(1));
        check("rst_scores", out_scores, '0);
        check("rst_cnt", PACKED_WIDTH'(out_class_cnt), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-term classes; argmax of these is class 1 (value 9)
        vals = '{5, 9, 1, 3, 7, 2, 8, 4, 6, 0};
        frame_single("single");
        check("single_slot1", PACKED_WIDTH'(out_scores[63:32]), PACKED_WIDTH'(9));
        check("single_scores", out_scores, pack_vals());
        check("single_in_ready", PACKED_WIDTH'(in_ready), '0);
        accept_out("single");

        // Multi-term class 0
        check("multi_cnt0", PACKED_WIDTH'(out_class_cnt), '0);
        beat(100, 1'b0);
        beat(200, 1'b0);
        check("multi_cnt0_mid", PACKED_WIDTH'(out_class_cnt), '0);
        beat(300, 1'b1);
        for (int k = 1; k < NUM_CLASSES; k++) begin
            check("multi_cnt", PACKED_WIDTH'(out_class_cnt), PACKED_WIDTH'(k));
            beat(1, 1'b1);
        end
        check("multi_valid", PACKED_WIDTH'(out_valid), PACKED_WIDTH'(1));
        vals = '{600, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        exp_vec = pack_vals();
        check("multi_slot0", PACKED_WIDTH'(out_scores[31:0]), PACKED_WIDTH'(600));
        check("multi_scores", out_scores, exp_vec);

        // Backpressure: pending term must not be consumed while in OUT
        in_valid = 1'b1; in_data = 55; in_last = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", PACKED_WIDTH'(in_ready), '0);
            check("bp_scores", out_scores, exp_vec);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("bp_valid_fall", PACKED_WIDTH'(out_valid), '0);
        check("bp_ready_back", PACKED_WIDTH'(in_ready), PACKED_WIDTH'(1));
        check("bp_no_consume", PACKED_WIDTH'(out_class_cnt), '0);

        // Overflow in class 0
        beat(32'hFFFF_FFFF, 1'b0);
        beat(32'd2, 1'b1);
        for (int k = 1; k < NUM_CLASSES; k++) beat(0, 1'b1);
`ifdef SCORE_SAT_EN
        check("ovf_slot0", PACKED_WIDTH'(out_scores[31:0]), PACKED_WIDTH'(32'hFFFF_FFFF));
`else
        check("ovf_slot0", PACKED_WIDTH'(out_scores[31:0]), PACKED_WIDTH'(1));
`endif
        accept_out("ovf");

        // Clear after 4 classes plus a partial term, with a term in the clear cycle
        for (int k = 0; k < 4; k++) beat(SCORE_WIDTH'(11 + k), 1'b1);
        beat(50, 1'b0);
        clear = 1'b1;
        beat(999, 1'b1);
        clear = 1'b0;
        check("clr_cnt", PACKED_WIDTH'(out_class_cnt), '0);
        check("clr_valid", PACKED_WIDTH'(out_valid), '0);
        check("clr_slot3_kept", PACKED_WIDTH'(out_scores[127:96]), PACKED_WIDTH'(14));
        beat(3, 1'b0);
        beat(4, 1'b1);
        for (int k = 1; k < NUM_CLASSES; k++) beat(SCORE_WIDTH'(20 + k), 1'b1);
        vals = '{7, 21, 22, 23, 24, 25, 26, 27, 28, 29};
        check("clr_valid_frame", PACKED_WIDTH'(out_valid), PACKED_WIDTH'(1));
        check("clr_scores", out_scores, pack_vals());
        check("clr_ready_out", PACKED_WIDTH'(in_ready), '0);

        // Asynchronous reset while in OUT
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", PACKED_WIDTH'(out_valid), '0);
        check("arst_scores", out_scores, '0);
        check("arst_ready", PACKED_WIDTH'(in_ready), PACKED_WIDTH'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vals = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
        frame_single("sevens");
        check("sevens_scores", out_scores, pack_vals());
        accept_out("sevens");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
